div_arbiter: RTL

Round-robin scheduler that shares one unsigned fixed-point divider among `N_REQ` requesters. It grants one pending request at a time, latches that request's operands and checks for a zero divisor locally. It sequences the divider's start/busy/valid protocol and returns the quotient plus a status code to the granted requester over a valid/ready response channel. It sits between the requester ports and the divider's `start`/`busy`/`valid` interface.

---
 rtl/div_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/div_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// Shared types for div_arbiter: FSM state encoding and response status codes.
package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    RUN,
    RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DVZ     = 2'b01;
  localparam logic [1:0] ST_OVF     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`, wrapping around.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic [IDW-1:0] idx;

  // Walk from farthest to nearest so the closest requester after `last` wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      idx = IDW'((int'(last) + off) % int'(N_REQ));
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one fixed-point divider among N_REQ requesters.
// Optional watchdog on the divider handshake: define DIV_ARB_TIMEOUT_EN.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_q,
  output logic [1:0]             rsp_status,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_a,
  output logic [WIDTH-1:0]       div_b,
  input  logic                   div_busy,
  input  logic                   div_valid,
  input  logic [WIDTH-1:0]       div_q
);

  if (N_REQ < 2 || TIMEOUT == 0) begin : g_bad_params
    $error("div_arbiter: N_REQ must be >= 2 and TIMEOUT nonzero");
  end

  state_t           state;
  logic [IDW-1:0]   last;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_a     = req_a[WIDTH*32'(grant_idx) +: WIDTH];
  assign sel_b     = req_b[WIDTH*32'(grant_idx) +: WIDTH];
  // Accept pulse is combinational so a request is granted in the cycle it is first seen.
  assign req_ready = (state == IDLE) ? grant : '0;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog;
  logic            expired;
  // Only fires when the divider has not already completed the step we are waiting on.
  assign expired = (wdog == WD_W'(TIMEOUT - 1)) &&
                   ((state == WAIT_BUSY && !div_busy) || (state == RUN && div_busy));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= IDW'(N_REQ - 1);
      div_a      <= '0;
      div_b      <= '0;
      div_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_q      <= '0;
      rsp_status <= ST_OK;
`ifdef DIV_ARB_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            div_a     <= sel_a;
            div_b     <= sel_b;
            rsp_id    <= grant_idx;
            div_start <= (sel_b != '0);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (div_b == '0) begin
            rsp_q      <= '0;
            rsp_status <= ST_DVZ;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (div_busy) state <= RUN;
        end
        RUN: begin
          if (!div_busy) begin
            rsp_valid  <= 1'b1;
            rsp_q      <= div_valid ? div_q : '0;
            rsp_status <= div_valid ? ST_OK : ST_OVF;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef DIV_ARB_TIMEOUT_EN
      if (state == ISSUE) wdog <= '0;
      else if (state == WAIT_BUSY || state == RUN) wdog <= wdog + WD_W'(1);
      if (expired) begin
        rsp_q      <= '0;
        rsp_status <= ST_TIMEOUT;
        rsp_valid  <= 1'b1;
        state      <= RESP;
      end
`endif
    end
  end

endmodule
